// File: rtl/data_table_result_collector_pkg.sv
// Shared hash-table types: result payload returned by the data-table search engines.
package data_table_result_collector_pkg;

  localparam int unsigned ENGINES_CNT_DEF = 3;
  localparam int unsigned ORDER_DEPTH_DEF = 8;
  localparam int unsigned KEY_W           = 8;
  localparam int unsigned VAL_W           = 16;

  typedef struct packed {
    logic             found;
    logic [KEY_W-1:0] key_id;
    logic [VAL_W-1:0] value;
  } ht_result_t;

endpackage

// File: rtl/data_table_result_collector_ht_order_fifo.sv
// Issue-order FIFO: remembers which engine each task went to; DEPTH must be a power of two.
module data_table_result_collector_ht_order_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push,
  input  logic [W-1:0]            push_data,
  input  logic                    pop,
  output logic [W-1:0]            head,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/data_table_result_collector.sv
// Merges per-engine search results into one ht_result_t stream.
// HT_RES_IN_ORDER_EN: release results in issue order; otherwise round-robin among valid engines.
module data_table_result_collector
  import data_table_result_collector_pkg::*;
#(
  parameter  int unsigned ENGINES_CNT = ENGINES_CNT_DEF,
  parameter  int unsigned ORDER_DEPTH = ORDER_DEPTH_DEF,
  localparam int unsigned ENG_W       = $clog2(ENGINES_CNT)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               issue_val_i,
  input  logic [ENG_W-1:0]                   issue_engine_i,
  output logic                               issue_ready_o,
  input  logic [ENGINES_CNT-1:0]             eng_res_valid_i,
  input  ht_result_t [ENGINES_CNT-1:0]       eng_res_i,
  output logic [ENGINES_CNT-1:0]             eng_res_ready_o,
  output ht_result_t                         res_o,
  output logic                               res_valid_o,
  input  logic                               res_ready_i,
  output logic                               err_overflow_o
);

  logic       ld;
  logic       xfer;
  ht_result_t sel_res;

  assign ld = !res_valid_o || res_ready_i;

  // Output register: load on transfer, drop valid once the held word is consumed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_o       <= '0;
      res_valid_o <= 1'b0;
    end else if (ld) begin
      res_valid_o <= xfer;
      if (xfer) res_o <= sel_res;
    end
  end

`ifdef HT_RES_IN_ORDER_EN
  localparam int unsigned CNT_W = $clog2(ORDER_DEPTH) + 1;

  logic [ENG_W-1:0] head_eng;
  logic [CNT_W-1:0] count;
  logic             fifo_empty;
  logic             push;

  assign fifo_empty    = (count == '0);
  assign issue_ready_o = (count != CNT_W'(ORDER_DEPTH));
  assign push          = issue_val_i && issue_ready_o;

  data_table_result_collector_ht_order_fifo #(
    .DEPTH (ORDER_DEPTH),
    .W     (ENG_W)
  ) u_order_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (push),
    .push_data (issue_engine_i),
    .pop       (xfer),
    .head      (head_eng),
    .count     (count)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                             err_overflow_o <= 1'b0;
    else if (issue_val_i && !issue_ready_o) err_overflow_o <= 1'b1;
  end

  // Only the engine at the FIFO head may hand over a result.
  always_comb begin
    eng_res_ready_o = '0;
    xfer            = 1'b0;
    sel_res         = '0;
    for (int unsigned i = 0; i < ENGINES_CNT; i++) begin
      if (ld && !fifo_empty && head_eng == ENG_W'(i)) begin
        eng_res_ready_o[i] = 1'b1;
        xfer               = eng_res_valid_i[i];
        sel_res            = eng_res_i[i];
      end
    end
  end
`else
  logic             unused_issue;
  logic [ENG_W-1:0] last_grant;
  logic [ENG_W-1:0] grant_idx;
  logic [ENG_W-1:0] cand;
  logic             found;

  assign unused_issue   = ^{issue_val_i, issue_engine_i};
  assign issue_ready_o  = 1'b1;
  assign err_overflow_o = 1'b0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     last_grant <= ENG_W'(ENGINES_CNT - 1);
    else if (xfer) last_grant <= grant_idx;
  end

  // Round-robin: first valid engine after the last one granted.
  always_comb begin
    eng_res_ready_o = '0;
    xfer            = 1'b0;
    sel_res         = '0;
    grant_idx       = last_grant;
    cand            = '0;
    found           = 1'b0;
    for (int unsigned k = 1; k <= ENGINES_CNT; k++) begin
      cand = ENG_W'((32'(last_grant) + k) % ENGINES_CNT);
      for (int unsigned i = 0; i < ENGINES_CNT; i++) begin
        if (!found && cand == ENG_W'(i) && eng_res_valid_i[i]) begin
          found     = 1'b1;
          grant_idx = cand;
        end
      end
    end
    for (int unsigned i = 0; i < ENGINES_CNT; i++) begin
      if (found && ld && grant_idx == ENG_W'(i)) begin
        eng_res_ready_o[i] = 1'b1;
        xfer               = 1'b1;
        sel_res            = eng_res_i[i];
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_table_result_collector.sv
// Directed bench for data_table_result_collector; covers both HT_RES_IN_ORDER_EN builds.
module tb_data_table_result_collector;
  import data_table_result_collector_pkg::*;

  localparam int unsigned N  = 3;
  localparam int unsigned EW = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 issue_val = 1'b0;
  logic [EW-1:0]        issue_engine = '0;
  logic                 issue_ready;
  logic [N-1:0]         eng_valid = '0;
  ht_result_t [N-1:0]   eng_res;
  logic [N-1:0]         eng_ready;
  ht_result_t           res;
  logic                 res_valid;
  logic                 res_ready = 1'b1;
  logic                 err_overflow;

  int n_chk  = 0;
  int n_fail = 0;

  data_table_result_collector #(
    .ENGINES_CNT (N),
    .ORDER_DEPTH (8)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .issue_val_i     (issue_val),
    .issue_engine_i  (issue_engine),
    .issue_ready_o   (issue_ready),
    .eng_res_valid_i (eng_valid),
    .eng_res_i       (eng_res),
    .eng_res_ready_o (eng_ready),
    .res_o           (res),
    .res_valid_o     (res_valid),
    .res_ready_i     (res_ready),
    .err_overflow_o  (err_overflow)
  );

  always #5 clk = ~clk;

  // Distinct, recognisable payload per engine.
  function automatic ht_result_t mk(input int unsigned e);
    ht_result_t r;
    r.found  = 1'b1;
    r.key_id = 8'(8'h10 + e);
    r.value  = 16'(16'hA5A0 + e * 16'h0101);
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
    n_chk++; if (res !== '0) begin n_fail++; $display("FAIL reset_res: got %h want 0", res); end
    n_chk++; if (eng_ready !== '0) begin n_fail++; $display("FAIL reset_eng_ready: got %b want 000", eng_ready); end
    n_chk++; if (err_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_overflow); end
    n_chk++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_issue_ready: got %b want 1", issue_ready); end
    rst = 1'b0;
    tick();
  endtask

`ifdef HT_RES_IN_ORDER_EN
  task automatic test_in_order;
    int unsigned exp_e [3] = '{2, 0, 1};
    logic [N-1:0] exp_rdy;
    res_ready = 1'b1;
    eng_valid = '0;
    for (int k = 0; k < 3; k++) begin
      issue_val = 1'b1; issue_engine = EW'(exp_e[k]);
      tick();
    end
    issue_val = 1'b0;
    eng_valid = 3'b111;
    #1;
    n_chk++; if (eng_ready !== 3'b100) begin n_fail++; $display("FAIL order_first_grant: got %b want 100", eng_ready); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_chk++; if (res_valid !== 1'b1 || res !== mk(exp_e[k])) begin n_fail++; $display("FAIL order_res%0d: got v=%b %h want v=1 %h", k, res_valid, res, mk(exp_e[k])); end
      exp_rdy = (k < 2) ? (N'(1) << exp_e[k+1]) : '0;
      n_chk++; if (eng_ready !== exp_rdy) begin n_fail++; $display("FAIL order_grant%0d: got %b want %b", k, eng_ready, exp_rdy); end
    end
    tick();
    n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL order_drain: res_valid got %b want 0", res_valid); end
    eng_valid = '0;
  endtask

  task automatic test_backpressure;
    issue_val = 1'b1; issue_engine = 2'd1; tick();
    issue_engine = 2'd2; tick();
    issue_val = 1'b0;
    eng_valid = 3'b111;
    res_ready = 1'b0;
    tick();
    n_chk++; if (res_valid !== 1'b1 || res !== mk(1)) begin n_fail++; $display("FAIL bp_load: got v=%b %h want v=1 %h", res_valid, res, mk(1)); end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_chk++; if (res !== mk(1) || res_valid !== 1'b1 || eng_ready !== '0) begin n_fail++; $display("FAIL bp_hold%0d: got v=%b %h rdy=%b want v=1 %h rdy=000", k, res_valid, res, eng_ready, mk(1)); end
    end
    res_ready = 1'b1;
    #1;
    n_chk++; if (eng_ready !== 3'b100) begin n_fail++; $display("FAIL bp_release_grant: got %b want 100", eng_ready); end
    tick();
    n_chk++; if (res !== mk(2)) begin n_fail++; $display("FAIL bp_release_res: got %h want %h", res, mk(2)); end
    tick();
    n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: res_valid got %b want 0", res_valid); end
    eng_valid = '0;
  endtask

  task automatic test_wrap;
    int unsigned seq [20];
    for (int c = 0; c < 20; c++) seq[c] = 32'((c * 2 + 1) % 3);
    res_ready = 1'b1;
    eng_valid = '0;
    for (int c = 0; c < 4; c++) begin
      issue_val = 1'b1; issue_engine = EW'(seq[c]);
      tick();
    end
    eng_valid = 3'b111;
    for (int c = 4; c < 20; c++) begin
      issue_engine = EW'(seq[c]);
      tick();
      n_chk++; if (res !== mk(seq[c-4]) || issue_ready !== 1'b1) begin n_fail++; $display("FAIL wrap_res%0d: got %h rdy=%b want %h rdy=1", c - 4, res, issue_ready, mk(seq[c-4])); end
    end
    issue_val = 1'b0;
    for (int c = 16; c < 20; c++) begin
      tick();
      n_chk++; if (res !== mk(seq[c]) || res_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_tail%0d: got v=%b %h want v=1 %h", c, res_valid, res, mk(seq[c])); end
    end
    tick();
    n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_empty: res_valid got %b want 0", res_valid); end
    eng_valid = '0;
  endtask

  task automatic test_overflow;
    res_ready = 1'b1;
    eng_valid = '0;
    for (int c = 0; c < 8; c++) begin
      issue_val = 1'b1; issue_engine = EW'(c % 3);
      tick();
    end
    issue_engine = 2'd2;
    n_chk++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_full: issue_ready got %b want 0", issue_ready); end
    n_chk++; if (err_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: err got %b want 0", err_overflow); end
    tick();
    issue_val = 1'b0;
    n_chk++; if (err_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: err got %b want 1", err_overflow); end
    tick();
    n_chk++; if (err_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: err got %b want 1", err_overflow); end
    eng_valid = 3'b111;
    for (int c = 0; c < 8; c++) begin
      tick();
      n_chk++; if (res !== mk(32'(c % 3)) || res_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_drain%0d: got v=%b %h want v=1 %h", c, res_valid, res, mk(32'(c % 3))); end
    end
    tick();
    n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_dropped: res_valid got %b want 0", res_valid); end
    eng_valid = '0;
  endtask

  task automatic test_reset_mid;
    res_ready = 1'b0;
    eng_valid = '0;
    for (int c = 0; c < 4; c++) begin
      issue_val = 1'b1; issue_engine = EW'(c % 3);
      tick();
    end
    issue_val = 1'b0;
    eng_valid = 3'b111;
    tick();
    n_chk++; if (res_valid !== 1'b1 || res !== mk(0)) begin n_fail++; $display("FAIL rmid_held: got v=%b %h want v=1 %h", res_valid, res, mk(0)); end
    rst = 1'b1;
    #1;
    n_chk++; if (res_valid !== 1'b0 || res !== '0) begin n_fail++; $display("FAIL rmid_out: got v=%b %h want v=0 0", res_valid, res); end
    n_chk++; if (issue_ready !== 1'b1 || err_overflow !== 1'b0) begin n_fail++; $display("FAIL rmid_flags: rdy=%b err=%b want 1 0", issue_ready, err_overflow); end
    rst = 1'b0;
    res_ready = 1'b1;
    #1;
    n_chk++; if (eng_ready !== '0) begin n_fail++; $display("FAIL rmid_no_grant: got %b want 000", eng_ready); end
    tick();
    n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_no_stale: res_valid got %b want 0", res_valid); end
    eng_valid = '0;
  endtask
`else
  task automatic test_rr_grants;
    logic [N-1:0] exp_rdy;
    res_ready = 1'b1;
    eng_valid = 3'b111;
    issue_val = 1'b1;
    issue_engine = 2'd1;
    #1;
    n_chk++; if (eng_ready !== 3'b001) begin n_fail++; $display("FAIL rr_first_grant: got %b want 001", eng_ready); end
    for (int k = 0; k < 6; k++) begin
      issue_engine = EW'((k + 2) % 3);
      tick();
      n_chk++; if (res_valid !== 1'b1 || res !== mk(32'(k % 3))) begin n_fail++; $display("FAIL rr_res%0d: got v=%b %h want v=1 %h", k, res_valid, res, mk(32'(k % 3))); end
      exp_rdy = N'(1) << ((k + 1) % 3);
      n_chk++; if (eng_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_grant%0d: got %b want %b", k, eng_ready, exp_rdy); end
    end
    n_chk++; if (issue_ready !== 1'b1 || err_overflow !== 1'b0) begin n_fail++; $display("FAIL rr_issue_ignored: rdy=%b err=%b want 1 0", issue_ready, err_overflow); end
    issue_val = 1'b0;
  endtask

  task automatic test_backpressure;
    res_ready = 1'b0;
    #1;
    n_chk++; if (eng_ready !== '0) begin n_fail++; $display("FAIL bp_stall: got %b want 000", eng_ready); end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_chk++; if (res !== mk(2) || res_valid !== 1'b1 || eng_ready !== '0) begin n_fail++; $display("FAIL bp_hold%0d: got v=%b %h rdy=%b want v=1 %h rdy=000", k, res_valid, res, eng_ready, mk(2)); end
    end
    res_ready = 1'b1;
    #1;
    n_chk++; if (eng_ready !== 3'b001) begin n_fail++; $display("FAIL bp_release_grant: got %b want 001", eng_ready); end
    tick();
    n_chk++; if (res !== mk(0)) begin n_fail++; $display("FAIL bp_release_res: got %h want %h", res, mk(0)); end
  endtask

  task automatic test_rr_subset;
    int unsigned exp_e [5] = '{2, 0, 2, 1, 1};
    eng_valid = 3'b101;
    for (int k = 0; k < 5; k++) begin
      if (k == 3) eng_valid = 3'b010;
      tick();
      n_chk++; if (res !== mk(exp_e[k]) || res_valid !== 1'b1) begin n_fail++; $display("FAIL rr_subset%0d: got v=%b %h want v=1 %h", k, res_valid, res, mk(exp_e[k])); end
    end
    eng_valid = '0;
    tick();
    n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rr_drain: res_valid got %b want 0", res_valid); end
  endtask

  task automatic test_reset_mid;
    eng_valid = 3'b111;
    res_ready = 1'b0;
    tick();
    n_chk++; if (res_valid !== 1'b1 || res !== mk(2)) begin n_fail++; $display("FAIL rmid_held: got v=%b %h want v=1 %h", res_valid, res, mk(2)); end
    rst = 1'b1;
    #1;
    n_chk++; if (res_valid !== 1'b0 || res !== '0) begin n_fail++; $display("FAIL rmid_out: got v=%b %h want v=0 0", res_valid, res); end
    rst = 1'b0;
    res_ready = 1'b1;
    #1;
    n_chk++; if (eng_ready !== 3'b001) begin n_fail++; $display("FAIL rmid_restart_grant: got %b want 001", eng_ready); end
    tick();
    n_chk++; if (res !== mk(0) || res_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_restart_res: got v=%b %h want v=1 %h", res_valid, res, mk(0)); end
    eng_valid = '0;
    tick();
  endtask
`endif

  initial begin
    for (int i = 0; i < N; i++) eng_res[i] = mk(32'(i));
    test_reset();
`ifdef HT_RES_IN_ORDER_EN
    test_in_order();
    test_backpressure();
    test_wrap();
    test_overflow();
    test_reset_mid();
`else
    test_rr_grants();
    test_backpressure();
    test_rr_subset();
    test_reset_mid();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
